seven_seg_scanner: RTL

Time-multiplexed 7-segment display driver for the stopwatch board. It consumes the packed BCD/hex digit values produced by the digit counter chain and scans them onto a common-anode display, one digit at a time. It snapshots the digits once per frame so the display never tears, and inserts a blanking guard between digits to suppress ghosting.

---
 rtl/seven_seg_scanner.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode 7-segment scanner with per-frame digit snapshot and blanking guard.
// Optional leading-zero blanking is enabled by defining SEVENSEG_LZB_EN.
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic                    frame_tick
);

    // state   | meaning
    // S_IDLE  | display dark, waiting for enable
    // S_BLANK | anodes off, cathodes already driving the current digit
    // S_SHOW  | anode of the current digit on
    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] sh_dig_q, sh_dig_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    tick_q, tick_d;
    logic [3:0]              digit_d;
    logic                    higher_nz;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_to_seg = 7'b1000000;
            4'h1: hex_to_seg = 7'b1111001;
            4'h2: hex_to_seg = 7'b0100100;
            4'h3: hex_to_seg = 7'b0110000;
            4'h4: hex_to_seg = 7'b0011001;
            4'h5: hex_to_seg = 7'b0010010;
            4'h6: hex_to_seg = 7'b0000010;
            4'h7: hex_to_seg = 7'b1111000;
            4'h8: hex_to_seg = 7'b0000000;
            4'h9: hex_to_seg = 7'b0010000;
            4'hA: hex_to_seg = 7'b0001000;
            4'hB: hex_to_seg = 7'b0000011;
            4'hC: hex_to_seg = 7'b1000110;
            4'hD: hex_to_seg = 7'b0100001;
            4'hE: hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        sh_dig_d = sh_dig_q;
        sh_dp_d  = sh_dp_q;
        if (!enable) begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d  = S_BLANK;
                    idx_d    = '0;
                    cnt_d    = '0;
                    sh_dig_d = digits_in;
                    sh_dp_d  = dp_in;
                end
                S_BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BLANK_LAST) state_d = S_SHOW;
                end
                S_SHOW: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_BLANK;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d    = '0;
                            sh_dig_d = digits_in;
                            sh_dp_d  = dp_in;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next-state values so the pins follow the FSM edge-for-edge.
    always_comb begin
        an_d      = '1;
        seg_d     = 7'h7F;
        dp_d      = 1'b1;
        digit_d   = sh_dig_d[{idx_d, 2'b00} +: 4];
        higher_nz = 1'b0;
        tick_d    = (state_d == S_SHOW) && (idx_d == IDX_LAST) && (cnt_d == CNT_LAST);
        if (state_d == S_SHOW) an_d[idx_d] = 1'b0;
        if (state_d != S_IDLE) begin
            seg_d = hex_to_seg(digit_d);
            dp_d  = ~sh_dp_d[idx_d];
`ifdef SEVENSEG_LZB_EN
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (k >= int'(idx_d) && sh_dig_d[4*k +: 4] != 4'd0) higher_nz = 1'b1;
            end
            if (idx_d != '0 && !higher_nz) seg_d = 7'h7F;
`else
            higher_nz = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            sh_dig_q <= '0;
            sh_dp_q  <= '0;
            an_q     <= '1;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            sh_dig_q <= sh_dig_d;
            sh_dp_q  <= sh_dp_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            tick_q   <= tick_d;
        end
    end

    assign an_n       = an_q;
    assign seg_n      = seg_q;
    assign dp_n       = dp_q;
    assign frame_tick = tick_q;

endmodule
